convolution_processor_ctrl: RTL

Sequencer for the convolution processor datapath. Computes the full linear convolution z[n] = sum over k of x[k]*y[n-k], for n = 0 .. sizeX+sizeY-2.
- x and y are read from two synchronous read memories.
- Each term goes through the shared 16-bit-product multiplier.
- Results accumulate per output sample, and each sample is written to the Z memory.
- Sits between the host register interface (start/sizes/done) and the X/Y/Z memories.

---
 rtl/convolution_processor_pkg.sv | 16 +
 rtl/convolution_processor_mult.sv | 17 +
 rtl/convolution_processor_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/convolution_processor_pkg.sv
// Shared definitions for the convolution processor: default widths and FSM states.
package convolution_processor_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ACC_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/convolution_processor_mult.sv
// Shared multiplier: unsigned full-width product of two samples.
module convolution_processor_mult
  import convolution_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] p
);

  // Purely combinational product
  always_comb begin
    p = a * b;
  end

endmodule

// File: rtl/convolution_processor_ctrl.sv
// Convolution sequencer: walks n and k, reads X/Y, accumulates products and
// writes one Z sample per output index.
module convolution_processor_ctrl
  import convolution_processor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   sizeX,
  input  logic [ADDR_WIDTH:0]   sizeY,
  output logic [ADDR_WIDTH-1:0] memX_addr,
  input  logic [DATA_WIDTH-1:0] memX_data,
  output logic [ADDR_WIDTH-1:0] memY_addr,
  input  logic [DATA_WIDTH-1:0] memY_data,
  output logic [ADDR_WIDTH:0]   memZ_addr,
  output logic [ACC_WIDTH-1:0]  memZ_data,
  output logic                  memZ_we,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SW = ADDR_WIDTH + 1;
  localparam int unsigned JW = ADDR_WIDTH + 3;
  localparam logic [SW-1:0] SIZE_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                   state;
  logic [SW-1:0]            szx, szy, n;
  logic [ADDR_WIDTH-1:0]    k;
  logic [ACC_WIDTH-1:0]     acc;
  logic signed [JW-1:0]     j;
  logic                     j_ok, k_last, n_last;
  logic [2*DATA_WIDTH-1:0]  prod_full;
  logic [ACC_WIDTH-1:0]     prod;

  convolution_processor_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .a(memX_data),
    .b(memY_data),
    .p(prod_full)
  );

  // Term index, validity and loop-end conditions
  always_comb begin
    j      = $signed({2'b00, n}) - $signed({3'b000, k});
    j_ok   = (j >= 0) && (j < $signed({2'b00, szy}));
    k_last = ({1'b0, k} == (szx - SW'(1)));
    n_last = ({1'b0, n} == ({1'b0, szx} + {1'b0, szy} - (SW+1)'(2)));
    prod   = ACC_WIDTH'(prod_full);
  end

  // State-decoded outputs; everything idles at zero outside its driving state
  always_comb begin
    memX_addr = '0;
    memY_addr = '0;
    memZ_addr = '0;
    memZ_data = '0;
    memZ_we   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ISSUE, MAC: begin
        busy = 1'b1;
        if (j_ok) begin
          memX_addr = k;
          memY_addr = j[ADDR_WIDTH-1:0];
        end
      end
      WRITE: begin
        busy      = 1'b1;
        memZ_we   = 1'b1;
        memZ_addr = n;
        memZ_data = acc;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // FSM, counters and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      szx   <= '0;
      szy   <= '0;
      n     <= '0;
      k     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            szx   <= (sizeX > SIZE_MAX) ? SIZE_MAX : sizeX;
            szy   <= (sizeY > SIZE_MAX) ? SIZE_MAX : sizeY;
            n     <= '0;
            k     <= '0;
            acc   <= '0;
            state <= ((sizeX == '0) || (sizeY == '0)) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (j_ok)        state <= MAC;
          else if (k_last) state <= WRITE;
          else             k     <= k + ADDR_WIDTH'(1);
        end
        MAC: begin
          acc <= acc + prod;
          if (k_last) begin
            state <= WRITE;
          end else begin
            k     <= k + ADDR_WIDTH'(1);
            state <= ISSUE;
          end
        end
        WRITE: begin
          if (n_last) begin
            state <= DONE;
          end else begin
            n     <= n + SW'(1);
            k     <= '0;
            acc   <= '0;
            state <= ISSUE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
